// File: rtl/shift_pkg.sv
// shift_pkg: shared mode/state enums and WIDTH/STEP legality check for the multi-cycle shifter
package shift_pkg;
  typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11} mode_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic bit params_ok(input int w, input int s);
    return w >= 2 && (w & (w - 1)) == 0 && s >= 1 && (s & (s - 1)) == 0 && s <= w;
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one-cycle shift of data by k (0..STEP) in mode via log2(STEP)+1 mux levels; outputs q and last bit shifted out (ROR: q MSB)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int LOG  = $clog2(STEP),
  localparam int KW   = LOG + 1
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  input  logic             sign,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] q,
  output logic             carry
);
  logic [WIDTH-1:0] d [LOG+2];
  logic             c [LOG+2];
  assign d[0] = data;
  assign c[0] = 1'b0;
  for (genvar i = 0; i <= LOG; i++) begin : g_lvl
    localparam int S = 1 << i;
    logic [WIDTH-1:0] sh;
    logic             co;
    assign sh = mode == LSL ? d[i] << S :
                mode == LSR ? d[i] >> S :
                mode == ASR ? (d[i] >> S) | (sign ? ~({WIDTH{1'b1}} >> S) : '0) :
                              (d[i] >> S) | (d[i] << (WIDTH - S));
    assign co = mode == LSL ? d[i][WIDTH-S] : mode == ROR ? sh[WIDTH-1] : d[i][S-1];
    assign d[i+1] = k[i] ? sh : d[i];
    assign c[i+1] = k[i] ? co : c[i];
  end
  assign q     = d[LOG+1];
  assign carry = c[LOG+1];
endmodule

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle LSL/LSR/ASR/ROR shifter; in_* valid/ready operand port, out_* valid/ready result port with carry/zero flags, busy
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);
  localparam int KW = $clog2(STEP) + 1;
  if (!params_ok(WIDTH, STEP)) begin : g_bad_params
    $error("shift_unit: WIDTH/STEP must be powers of two with WIDTH >= 2 and 1 <= STEP <= WIDTH");
  end
  state_t           state, state_n;
  mode_t            mode_q;
  logic             sign_q;
  logic [SHW-1:0]   rem;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_q;
  logic             step_c;
  assign k = int'(rem) >= STEP ? KW'(STEP) : KW'(rem);
  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data (out_data),
    .mode (mode_q),
    .sign (sign_q),
    .k    (k),
    .q    (step_q),
    .carry(step_c)
  );
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? (in_amt == '0 ? DONE : SHIFT) : IDLE) :
              state == SHIFT ? (rem == SHW'(k) ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= rst_n ? state_n : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      rem       <= '0;
      sign_q    <= 1'b0;
      mode_q    <= LSL;
    end else if (state == IDLE && in_valid) begin
      out_data  <= in_data;
      out_carry <= 1'b0;
      out_zero  <= in_data == '0;
      rem       <= in_amt;
      sign_q    <= in_data[WIDTH-1];
      mode_q    <= mode_t'(in_mode);
    end else if (state == SHIFT) begin
      out_data  <= step_q;
      out_carry <= step_c;
      out_zero  <= step_q == '0;
      rem       <= rem - SHW'(k);
    end
  end
  assign in_ready  = rst_n && state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed + random scoreboard bench for shift_unit at WIDTH=32, STEP=4
module tb_shift_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        busy;
  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        z;
    int          lat;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_carry(out_carry),
    .out_zero (out_zero),
    .busy     (busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    exp_t e;
    logic [32:0] l, r;
    logic [63:0] w;
    l = {1'b0, d} << a;
    r = {d, 1'b0} >> a;
    w = {d, d} >> a;
    case (m)
      2'b00:   begin e.d = l[31:0]; e.c = l[32]; end
      2'b01:   begin e.d = d >> a; e.c = r[0]; end
      2'b10:   begin e.d = 32'($signed(d) >>> a); e.c = r[0]; end
      default: begin e.d = w[31:0]; e.c = (a != 5'd0) && w[31]; end
    endcase
    e.z = e.d == 32'd0;
    e.lat = 1 + (int'(a) + 3) / 4;
    return e;
  endfunction
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    q.push_back(model(d, a, m));
    in_valid = 1'b1;
    in_data = d;
    in_amt = a;
    in_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = $urandom;
    in_amt = 5'($urandom_range(0, 31));
    in_mode = 2'($urandom_range(0, 3));
  endtask
  task automatic recv(input int hold);
    exp_t e;
    int c = 1;
    while (!out_valid && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    e = q.pop_front();
    chk("latency", 32'(c), 32'(e.lat));
    chk("data", out_data, e.d);
    chk("carry", 32'(out_carry), 32'(e.c));
    chk("zero", 32'(out_zero), 32'(e.z));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data = 32'hDEADBEEF;
      in_amt = 5'd3;
      in_mode = 2'b00;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, e.d);
      chk("hold_carry", 32'(out_carry), 32'(e.c));
      chk("hold_zero", 32'(out_zero), 32'(e.z));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(32'h80000001, 5'd1, 2'b01);  recv(0);
    send(32'hFFFFFFFF, 5'd13, 2'b01); recv(0);
    send(32'h80000000, 5'd31, 2'b10); recv(0);
    send(32'h7FFFFFFF, 5'd31, 2'b10); recv(0);
    send(32'h0000000F, 5'd4, 2'b11);  recv(0);
    send(32'hF0000000, 5'd4, 2'b00);  recv(0);
    for (int m = 0; m < 4; m++) begin
      send(32'h12345678, 5'd0, 2'(m));
      recv(0);
    end
    send(32'hA5A5A5A5, 5'd7, 2'b11);  recv(5);
    send(32'h0F0F0F0F, 5'd9, 2'b00);  recv(0);
    send(32'hC0000003, 5'd20, 2'b01);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    send(32'h80000001, 5'd17, 2'b10); recv(0);
    for (int i = 0; i < 16; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      recv(i % 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
